cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single physical-memory port between the I-cache and D-cache miss/writeback paths.
//  Sits between both caches and pmem; one transaction in flight at a time.
//  Latches the winner's request, holds it until pmem_resp, then routes response and data back.
//  Round-robin on simultaneous requests so neither fetch nor LDI/STI/LDR/STR traffic starves.
// PARAMETERS
//  ADDR_W  16   physical address width (lc3b_word)
//  LINE_W  128  cache line width in bits (lc3b_c_line)
// PORTS
//  clk           in   1       system clock, all state on posedge
//  reset         in   1       synchronous, active-high reset
//  i_read        in   1       I-cache line-fill request (I-cache never writes)
//  i_address     in   ADDR_W  I-cache line address
//  i_rdata       out  LINE_W  fill data to I-cache
//  i_resp        out  1       I-cache transaction done
//  d_read        in   1       D-cache line-fill request
//  d_write       in   1       D-cache writeback request
//  d_address     in   ADDR_W  D-cache line address
//  d_wdata       in   LINE_W  D-cache writeback data
//  d_rdata       out  LINE_W  fill data to D-cache
//  d_resp        out  1       D-cache transaction done
//  pmem_read     out  1       read strobe to pmem
//  pmem_write    out  1       write strobe to pmem
//  pmem_address  out  ADDR_W  latched request address
//  pmem_wdata    out  LINE_W  latched writeback data
//  pmem_rdata    in   LINE_W  pmem read data
//  pmem_resp     in   1       pmem done, 1-cycle pulse
// BEHAVIOUR
//  States: IDLE, SERVE_I, SERVE_D, DONE. Reset -> IDLE, last_grant=I, all outputs 0.
//  IDLE: i_req=i_read; d_req=d_read|d_write. Only one req -> grant it. Both -> grant ~last_grant.
//   On grant: latch address/wdata/op into req regs, set last_grant, go SERVE_x next edge.
//  SERVE_x: pmem_read/pmem_write driven from latched op (registered: first strobe 1 cycle after req).
//   Strobes held constant until pmem_resp; latched regs never change while in SERVE_x.
//   pmem_resp: owner's x_resp=1 same cycle (combinational), x_rdata=pmem_rdata; go DONE.
//  DONE: one dead cycle, no strobes, no grant -> lets requester drop its stale read/write.
//   Always -> IDLE.
//  i_rdata/d_rdata = pmem_rdata unconditionally; only x_resp qualifies them.
//  x_resp never asserted for non-owner; never both resps in one cycle.
//  d_read&d_write together: illegal; arbiter treats as write (d_write wins).
//  Requester dropping req mid-SERVE: ignored; transaction completes from latched regs, resp still pulses.
//  pmem_resp outside SERVE_x: ignored, no state change.
//  Reset mid-transaction: next edge -> IDLE, strobes 0, resps 0, last_grant=I.
//  Min latency: req@t -> strobe@t+1 -> resp same cycle as pmem_resp; back-to-back grants >= 3 cycles apart.
// STRUCTURE
//  lc3b_types: add lc3b_c_line (logic [127:0]) and arb_state_t enum {IDLE,SERVE_I,SERVE_D,DONE}.
//  Single module; no sub-module warranted (FSM + request latch + output mux, ~150 lines).
// TESTING
//  1 I only: i_read, addr 16'h1230, pmem_resp after 4 cycles w/ rdata A5..A5 -> pmem_read,
//    pmem_address=1230, i_resp 1 cycle, i_rdata=A5..A5, d_resp=0.
//  2 D writeback: d_write, addr 16'h4440, wdata 0123..CDEF -> pmem_write only, pmem_wdata match, d_resp pulse.
//  3 Tie after reset: i_read&d_read same cycle -> D served first, then I; swap tie next time -> I first.
//  4 Continuous both reqs x6 txns -> grants alternate D,I,D,I,D,I; DONE cycle between each.
//  5 Req drop: i_read low mid-SERVE_I, addr input changed -> pmem_address still old, i_resp still pulses.
//  6 Reset 2 cycles into SERVE_D -> next cycle strobes 0, state IDLE; late pmem_resp gives no d_resp.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/pmem arbiter: line and word types, arbiter state and grant encoding.
package cache_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_LINE_W = 128;

  typedef logic [ARB_ADDR_W-1:0] lc3b_word;
  typedef logic [ARB_LINE_W-1:0] lc3b_c_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one pmem port between I-cache fills and D-cache fills/writebacks.
//   state   | meaning
//   IDLE    | no transaction, pick a winner (tie -> opposite of last grant)
//   SERVE_I | I-cache request latched, strobing pmem until pmem_resp
//   SERVE_D | D-cache request latched, strobing pmem until pmem_resp
//   DONE    | dead cycle so the served requester can drop its stale request
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q, state_d;
  grant_t            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;

  logic i_req, d_req, pick_d, serving;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    i_req   = i_read;
    d_req   = d_read | d_write;
    // D wins when alone, or on a tie when I was granted last.
    pick_d  = d_req && (!i_req || (last_q == GRANT_I));
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = SERVE_D;
          last_d  = GRANT_D;
          addr_d  = d_address;
          wdata_d = d_wdata;
          write_d = d_write;
        end else if (i_req) begin
          state_d = SERVE_I;
          last_d  = GRANT_I;
          addr_d  = i_address;
          wdata_d = '0;
          write_d = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read    = serving && !write_q;
  assign pmem_write   = serving && write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = (state_q == SERVE_I) && pmem_resp;
  assign d_resp       = (state_q == SERVE_D) && pmem_resp;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin model.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_read, d_read, d_write, pmem_resp;
  logic [15:0]  i_address, d_address, pmem_address;
  logic [127:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;

  int n_cmp = 0;
  int n_bad = 0;
  int model_last;  // 0 = I granted last, 1 = D granted last

  cache_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic do_reset();
    drop_reqs();
    pmem_resp = 1'b0;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    model_last = 0;
  endtask

  // Runs one grant edge, lat strobe cycles, a response pulse and the following dead cycle;
  // returns what was observed so each test can judge it.
  task automatic observe(input int lat, input logic [127:0] rd,
                         output logic sr, output logic sw, output logic [15:0] sa,
                         output logic [127:0] swd, output bit stable,
                         output logic ir, output logic dr,
                         output logic [127:0] ird, output logic [127:0] drd,
                         output logic dead);
    cyc();
    sr = pmem_read; sw = pmem_write; sa = pmem_address; swd = pmem_wdata;
    stable = 1'b1;
    for (int k = 1; k < lat; k++) begin
      cyc();
      if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {sr, sw, sa, swd} ||
          i_resp !== 1'b0 || d_resp !== 1'b0)
        stable = 1'b0;
    end
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    ir = i_resp; dr = d_resp; ird = i_rdata; drd = d_rdata;
    cyc();
    #1;
    dead = pmem_read | pmem_write | i_resp | d_resp;
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    i_read = 1'b1; d_write = 1'b1; pmem_resp = 1'b0;
    reset = 1'b1;
    cyc(); cyc();
    n_cmp++;
    if ({pmem_read, pmem_write, i_resp, d_resp, pmem_address} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {pmem_read, pmem_write, i_resp, d_resp, pmem_address});
    end
    do_reset();
    pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_stray_resp: got %b want 00", {i_resp, d_resp});
    end
    cyc();
    pmem_resp = 1'b0;
    n_cmp++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_stray_strobe: got %b want 00", {pmem_read, pmem_write});
    end
  endtask

  task automatic test_i_only();
    logic sr, sw, ir, dr, dead;
    logic [15:0] sa;
    logic [127:0] swd, ird, drd;
    bit stable;
    do_reset();
    i_read = 1'b1; i_address = 16'h1230;
    observe(4, {16{8'hA5}}, sr, sw, sa, swd, stable, ir, dr, ird, drd, dead);
    drop_reqs();
    cyc();
    n_cmp++;
    if ({sr, sw} !== 2'b10) begin
      n_bad++; $display("FAIL i_only_strobes: got %b want 10", {sr, sw});
    end
    n_cmp++;
    if (sa !== 16'h1230) begin
      n_bad++; $display("FAIL i_only_addr: got %h want 1230", sa);
    end
    n_cmp++;
    if ({stable, ir, dr, dead} !== 4'b1100) begin
      n_bad++; $display("FAIL i_only_resp: stable/ir/dr/dead got %b want 1100",
                        {stable, ir, dr, dead});
    end
    n_cmp++;
    if (ird !== {16{8'hA5}}) begin
      n_bad++; $display("FAIL i_only_rdata: got %h want a5..a5", ird);
    end
  endtask

  task automatic test_d_write();
    logic sr, sw, ir, dr, dead;
    logic [15:0] sa;
    logic [127:0] swd, ird, drd;
    bit stable;
    do_reset();
    d_write = 1'b1; d_address = 16'h4440;
    d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    observe(3, 128'h0, sr, sw, sa, swd, stable, ir, dr, ird, drd, dead);
    drop_reqs();
    cyc();
    n_cmp++;
    if ({sr, sw, stable, ir, dr, dead} !== 6'b011010) begin
      n_bad++; $display("FAIL dwr_ctrl: r/w/stable/ir/dr/dead got %b want 011010",
                        {sr, sw, stable, ir, dr, dead});
    end
    n_cmp++;
    if (sa !== 16'h4440 || swd !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
      n_bad++; $display("FAIL dwr_data: got %h/%h want 4440/0123..cdef", sa, swd);
    end
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h5550; d_wdata = 128'h77;
    observe(2, 128'h0, sr, sw, sa, swd, stable, ir, dr, ird, drd, dead);
    drop_reqs();
    cyc();
    n_cmp++;
    if ({sr, sw, dr, sa, swd} !== {3'b011, 16'h5550, 128'h77}) begin
      n_bad++; $display("FAIL drw_both_is_write: got r%b w%b d%b %h %h want w, 5550, 77",
                        sr, sw, dr, sa, swd);
    end
  endtask

  task automatic test_tie();
    logic sr, sw, ir, dr, dead;
    logic [15:0] sa;
    logic [127:0] swd, ird, drd;
    bit stable;
    logic exp_d;
    do_reset();
    i_read = 1'b1; i_address = 16'h1000;
    d_read = 1'b1; d_address = 16'h2000;
    for (int t = 0; t < 3; t++) begin
      exp_d = (t != 1);
      observe(2, rnd128(), sr, sw, sa, swd, stable, ir, dr, ird, drd, dead);
      cyc();
      n_cmp++;
      if ({dr, ir} !== {exp_d, !exp_d} || sa !== (exp_d ? 16'h2000 : 16'h1000)) begin
        n_bad++; $display("FAIL tie_%0d: got d%b i%b addr %h want d%b", t, dr, ir, sa, exp_d);
      end
    end
    drop_reqs();
    cyc();
  endtask

  task automatic test_continuous();
    logic sr, sw, ir, dr, dead;
    logic [15:0] sa;
    logic [127:0] swd, ird, drd, rd;
    bit stable;
    logic exp_d, idle_strobe;
    do_reset();
    i_read = 1'b1; i_address = 16'h0AA0;
    d_read = 1'b1; d_address = 16'h0BB0;
    for (int t = 0; t < 6; t++) begin
      exp_d = (t % 2 == 0);
      rd = rnd128();
      observe($urandom_range(1, 4), rd, sr, sw, sa, swd, stable, ir, dr, ird, drd, dead);
      cyc();
      idle_strobe = pmem_read | pmem_write;
      n_cmp++;
      if ({dr, ir, stable, dead, idle_strobe} !== {exp_d, !exp_d, 3'b100} ||
          (exp_d ? drd : ird) !== rd) begin
        n_bad++; $display("FAIL cont_%0d: d%b i%b stable%b dead%b idle%b want d%b",
                          t, dr, ir, stable, dead, idle_strobe, exp_d);
      end
    end
    drop_reqs();
    cyc();
  endtask

  task automatic test_req_drop();
    do_reset();
    i_read = 1'b1; i_address = 16'h1230;
    cyc();
    i_read = 1'b0; i_address = 16'hFFFF;
    cyc(); cyc();
    n_cmp++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h1230}) begin
      n_bad++; $display("FAIL drop_latched: got r%b %h want r1 1230", pmem_read, pmem_address);
    end
    pmem_rdata = 128'h5A; pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b10) begin
      n_bad++; $display("FAIL drop_resp: got i%b d%b want i1 d0", i_resp, d_resp);
    end
    cyc();
    pmem_resp = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic sr, sw, ir, dr, dead;
    logic [15:0] sa;
    logic [127:0] swd, ird, drd;
    bit stable;
    do_reset();
    d_read = 1'b1; d_address = 16'h4440;
    cyc(); cyc();
    d_read = 1'b0;
    reset = 1'b1;
    cyc();
    n_cmp++;
    if ({pmem_read, pmem_write, i_resp, d_resp, pmem_address} !== 20'h0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h want 0",
                        {pmem_read, pmem_write, i_resp, d_resp, pmem_address});
    end
    reset = 1'b0;
    pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b00) begin
      n_bad++; $display("FAIL midreset_late_resp: got i%b d%b want 00", i_resp, d_resp);
    end
    cyc();
    pmem_resp = 1'b0;
    model_last = 0;
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h0200;
    observe(1, 128'h1, sr, sw, sa, swd, stable, ir, dr, ird, drd, dead);
    drop_reqs();
    cyc();
    n_cmp++;
    if ({dr, ir, sa} !== {2'b10, 16'h0200}) begin
      n_bad++; $display("FAIL midreset_last_grant: got d%b i%b %h want D first", dr, ir, sa);
    end
  endtask

  task automatic test_random();
    logic sr, sw, ir, dr, dead;
    logic [15:0] sa, ia, da;
    logic [127:0] swd, ird, drd, rd, wd;
    bit stable;
    int want_i, want_d, dop, owner;
    logic exp_w;
    logic [15:0] exp_a;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      want_i = $urandom_range(0, 1);
      want_d = (want_i == 0) ? 1 : $urandom_range(0, 1);
      dop = $urandom_range(0, 2);  // 0 read, 1 write, 2 both (treated as write)
      ia = 16'($urandom); da = 16'($urandom); wd = rnd128(); rd = rnd128();
      if (want_i && want_d) owner = (model_last == 0) ? 1 : 0;
      else owner = want_d;
      model_last = owner;
      exp_w = (owner == 1) && (dop != 0);
      exp_a = (owner == 1) ? da : ia;
      i_read = 1'(want_i); i_address = ia;
      d_read = 1'(want_d != 0 && dop != 1); d_write = 1'(want_d != 0 && dop != 0);
      d_address = da; d_wdata = wd;
      observe($urandom_range(1, 5), rd, sr, sw, sa, swd, stable, ir, dr, ird, drd, dead);
      drop_reqs();
      cyc();
      n_cmp++;
      if ({sr, sw, sa} !== {!exp_w, exp_w, exp_a} || (exp_w && swd !== wd)) begin
        n_bad++; $display("FAIL rand_req_%0d: got r%b w%b %h want r%b w%b %h",
                          t, sr, sw, sa, !exp_w, exp_w, exp_a);
      end
      n_cmp++;
      if ({ir, dr, stable, dead} !== {owner == 0, owner == 1, 2'b10} ||
          ((owner == 1) ? drd : ird) !== rd) begin
        n_bad++; $display("FAIL rand_resp_%0d: got i%b d%b stable%b dead%b want owner %0d",
                          t, ir, dr, stable, dead, owner);
      end
    end
  endtask

  initial begin
    reset = 1'b1; pmem_resp = 1'b0; pmem_rdata = '0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    test_reset();
    test_i_only();
    test_d_write();
    test_tie();
    test_continuous();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
